// File: rtl/modulo_mef_enchimento_vedacao_param_if.sv
// Station bus for the filling/sealing controller: sensor/command inputs
// from the station side, actuator and status outputs from the controller.
interface modulo_mef_enchimento_vedacao_param_if #(
    parameter int CORK_CAP   = 2,
    parameter int BATCH_SIZE = 3
);
    localparam int CW = $clog2(CORK_CAP + 1);
    localparam int BW = $clog2(BATCH_SIZE + 1);

    logic          enable;
    logic          pg;
    logic          ch;
    logic          eb;
    logic          reload;
    logic          ack;
    logic          m;
    logic          ev;
    logic          ve;
    logic          al;
    logic          flt;
    logic [2:0]    state;
    logic [CW-1:0] corks_left;
    logic [BW-1:0] bottle_count;
    logic          batch_done;

    modport master (
        output enable, pg, ch, eb, reload, ack,
        input  m, ev, ve, al, flt, state, corks_left, bottle_count, batch_done
    );

    modport slave (
        input  enable, pg, ch, eb, reload, ack,
        output m, ev, ve, al, flt, state, corks_left, bottle_count, batch_done
    );
endinterface

// File: rtl/modulo_mef_enchimento_vedacao_param.sv
// Filling/sealing controller for one conveyor bottle station: fill timeout
// fault, timed seal pulse, cork magazine tracking and batch counting.
module modulo_mef_enchimento_vedacao_param #(
    parameter int FILL_TIMEOUT = 8,
    parameter int SEAL_CYCLES  = 3,
    parameter int CORK_CAP     = 2,
    parameter int BATCH_SIZE   = 3
) (
    input  logic clk,
    input  logic rst,
    modulo_mef_enchimento_vedacao_param_if.slave bus
);
    localparam int CW = $clog2(CORK_CAP + 1);
    localparam int BW = $clog2(BATCH_SIZE + 1);
    localparam int FW = $clog2(FILL_TIMEOUT);
    localparam int SW = $clog2(SEAL_CYCLES + 1);

    localparam logic [FW-1:0] FILL_LAST  = FW'(FILL_TIMEOUT - 1);
    localparam logic [SW-1:0] SEAL_LAST  = SW'(SEAL_CYCLES - 1);
    localparam logic [CW-1:0] CORK_FULL  = CW'(CORK_CAP);
    localparam logic [BW-1:0] BATCH_LAST = BW'(BATCH_SIZE - 1);

    typedef enum logic [2:0] {
        ST_MOVE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_SEAL   = 3'd2,
        ST_EJECT  = 3'd3,
        ST_NOCORK = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [FW-1:0] fill_tmr_q, fill_tmr_d;
    logic [SW-1:0] seal_cnt_q, seal_cnt_d;
    logic [CW-1:0] corks_q, corks_d, corks_run_s;
    logic [BW-1:0] bottles_q, bottles_d;
    logic          batch_done_q, batch_done_d;
    logic          run_s;
    logic          m_s, ev_s, ve_s, al_s, flt_s;

    function automatic logic state_legal(input logic [2:0] code);
        return (code <= 3'd5);
    endfunction

    assign run_s = bus.enable & ~bus.eb;

    // State, timers and counters; everything returns to its idle value on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_MOVE;
            fill_tmr_q   <= '0;
            seal_cnt_q   <= '0;
            corks_q      <= CORK_FULL;
            bottles_q    <= '0;
            batch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_tmr_q   <= fill_tmr_d;
            seal_cnt_q   <= seal_cnt_d;
            corks_q      <= corks_d;
            bottles_q    <= bottles_d;
            batch_done_q <= batch_done_d;
        end
    end

    // Next-state logic; transitions only advance while enabled and not blocked.
    always_comb begin
        state_d      = state_q;
        fill_tmr_d   = fill_tmr_q;
        seal_cnt_d   = seal_cnt_q;
        corks_run_s  = corks_q;
        bottles_d    = bottles_q;
        batch_done_d = 1'b0;

        if (run_s) begin
            case (state_q)
                ST_MOVE: begin
                    if (bus.pg) begin
                        state_d    = ST_FILL;
                        fill_tmr_d = '0;
                    end else begin
                        state_d    = ST_MOVE;
                    end
                end
                ST_FILL: begin
                    // A full bottle wins over a timeout landing on the same edge.
                    if (bus.ch) begin
                        if (corks_q != '0) begin
                            state_d = ST_SEAL;
                        end else begin
                            state_d = ST_NOCORK;
                        end
                    end else if (fill_tmr_q == FILL_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        fill_tmr_d = fill_tmr_q + FW'(1);
                    end
                end
                ST_SEAL: begin
                    if (seal_cnt_q == SEAL_LAST) begin
                        seal_cnt_d  = '0;
                        corks_run_s = corks_q - CW'(1);
                        state_d     = ST_EJECT;
                        if (bottles_q == BATCH_LAST) begin
                            bottles_d    = '0;
                            batch_done_d = 1'b1;
                        end else begin
                            bottles_d    = bottles_q + BW'(1);
                        end
                    end else begin
                        seal_cnt_d = seal_cnt_q + SW'(1);
                    end
                end
                ST_EJECT: begin
                    if (!bus.pg) begin
                        state_d = ST_MOVE;
                    end else begin
                        state_d = ST_EJECT;
                    end
                end
                ST_NOCORK: begin
                    if (bus.reload) begin
                        state_d    = ST_SEAL;
                        seal_cnt_d = '0;
                    end else begin
                        state_d    = ST_NOCORK;
                    end
                end
                ST_FAULT: begin
                    if (bus.ack) begin
                        state_d = ST_EJECT;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
                default: begin
                    state_d    = ST_MOVE;
                    fill_tmr_d = '0;
                    seal_cnt_d = '0;
                end
            endcase
        end else if (!state_legal(state_q)) begin
            state_d = ST_MOVE;
        end else begin
            state_d = state_q;
        end

        // A magazine refill always lands, even over a same-cycle cork use.
        if (bus.reload) begin
            corks_d = CORK_FULL;
        end else begin
            corks_d = corks_run_s;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        m_s   = 1'b0;
        ev_s  = 1'b0;
        ve_s  = 1'b0;
        al_s  = 1'b0;
        flt_s = 1'b0;
        case (state_q)
            ST_MOVE:   m_s  = 1'b1;
            ST_FILL:   ev_s = 1'b1;
            ST_SEAL:   ve_s = 1'b1;
            ST_EJECT:  m_s  = 1'b1;
            ST_NOCORK: al_s = 1'b1;
            ST_FAULT: begin
                al_s  = 1'b1;
                flt_s = 1'b1;
            end
            default: begin
                m_s   = 1'b0;
                al_s  = 1'b0;
            end
        endcase
    end

    assign bus.m            = m_s  & run_s;
    assign bus.ev           = ev_s & run_s;
    assign bus.ve           = ve_s & run_s;
    assign bus.al           = al_s | (bus.enable & bus.eb);
    assign bus.flt          = flt_s;
    assign bus.state        = state_q;
    assign bus.corks_left   = corks_q;
    assign bus.bottle_count = bottles_q;
    assign bus.batch_done   = batch_done_q;

endmodule

// File: tb/tb_modulo_mef_enchimento_vedacao_param.sv
// Directed bench: a cycle model of the station rules checked every cycle,
// plus hand-computed expectations along each scenario.
module tb_modulo_mef_enchimento_vedacao_param;
    localparam int FT  = 8;
    localparam int SC  = 3;
    localparam int CAP = 2;
    localparam int BS  = 3;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    modulo_mef_enchimento_vedacao_param_if #(.CORK_CAP(CAP), .BATCH_SIZE(BS)) bus ();

    modulo_mef_enchimento_vedacao_param #(
        .FILL_TIMEOUT(FT), .SEAL_CYCLES(SC), .CORK_CAP(CAP), .BATCH_SIZE(BS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Station model: phase 0 move,1 fill,2 seal,3 eject,4 no cork,5 fault.
    int md_phase, md_fill_spent, md_seal_done, md_corks, md_bottles;
    bit md_bd;

    always @(posedge clk or posedge rst) begin : model
        int ph, fs, sd, ck, bt;
        bit bd;
        if (rst) begin
            md_phase      <= 0;
            md_fill_spent <= 0;
            md_seal_done  <= 0;
            md_corks      <= CAP;
            md_bottles    <= 0;
            md_bd         <= 1'b0;
        end else begin
            ph = md_phase; fs = md_fill_spent; sd = md_seal_done;
            ck = md_corks; bt = md_bottles; bd = 1'b0;
            if (bus.enable && !bus.eb) begin
                case (ph)
                    0: if (bus.pg) begin ph = 1; fs = 0; end
                    1: if (bus.ch) ph = (ck > 0) ? 2 : 4;
                       else if (fs + 1 >= FT) ph = 5;
                       else fs = fs + 1;
                    2: begin
                        sd = sd + 1;
                        if (sd == SC) begin
                            sd = 0; ck = ck - 1; ph = 3;
                            bt = (bt + 1) % BS;
                            bd = (bt == 0);
                        end
                    end
                    3: if (!bus.pg) ph = 0;
                    4: if (bus.reload) ph = 2;
                    5: if (bus.ack) ph = 3;
                    default: ph = 0;
                endcase
            end
            if (bus.reload) ck = CAP;
            md_phase <= ph; md_fill_spent <= fs; md_seal_done <= sd;
            md_corks <= ck; md_bottles <= bt; md_bd <= bd;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    bit run_m;
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            run_m = bus.enable && !bus.eb;
            chk("m",     bus.m,  int'(run_m && (md_phase == 0 || md_phase == 3)));
            chk("ev",    bus.ev, int'(run_m && md_phase == 1));
            chk("ve",    bus.ve, int'(run_m && md_phase == 2));
            chk("al",    bus.al, int'(md_phase == 4 || md_phase == 5 || (bus.enable && bus.eb)));
            chk("flt",   bus.flt, int'(md_phase == 5));
            chk("state", bus.state, md_phase);
            chk("corks", bus.corks_left, md_corks);
            chk("bottles", bus.bottle_count, md_bottles);
            chk("batch_done", bus.batch_done, int'(md_bd));
        end
    end

    task automatic nx();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1;
        bus.enable = 1'b1; bus.eb = 1'b0; bus.pg = 1'b0;
        bus.ch = 1'b0; bus.reload = 1'b0; bus.ack = 1'b0;
        nx();
        rst = 1'b0;
        chk("rst_state", bus.state, 0);
        chk("rst_m", bus.m, 1);
        chk("rst_ev", bus.ev, 0);
        chk("rst_corks", bus.corks_left, 2);
        chk("rst_bottles", bus.bottle_count, 0);
        chk("rst_flt", bus.flt, 0);

        // 1: normal bottle
        bus.pg = 1'b1;
        nx();
        chk("s1_fill", bus.state, 1); chk("s1_ev", bus.ev, 1); chk("s1_m", bus.m, 0);
        repeat (3) nx();
        bus.ch = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            nx();
            bus.ch = 1'b0;
            if (bus.ve) cnt++; else break;
        end
        chk("s1_ve_cycles", cnt, 3);
        chk("s1_eject", bus.state, 3);
        chk("s1_corks", bus.corks_left, 1);
        chk("s1_bottles", bus.bottle_count, 1);
        bus.pg = 1'b0;
        nx();
        chk("s1_move", bus.state, 0);

        // 2: fill timeout
        bus.pg = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            nx();
            if (bus.ev) cnt++; else break;
        end
        chk("s2_ev_cycles", cnt, 8);
        chk("s2_fault", bus.state, 5); chk("s2_al", bus.al, 1); chk("s2_flt", bus.flt, 1);
        nx();
        chk("s2_fault_hold", bus.state, 5);
        bus.ack = 1'b1;
        nx();
        bus.ack = 1'b0;
        chk("s2_ack_eject", bus.state, 3); chk("s2_flt_clr", bus.flt, 0);
        bus.pg = 1'b0;
        nx();
        bus.pg = 1'b1;
        nx();
        chk("s2b_fill", bus.state, 1);
        repeat (7) nx();
        chk("s2b_still_fill", bus.state, 1);
        bus.ch = 1'b1;
        nx();
        bus.ch = 1'b0;
        chk("s2b_seal", bus.state, 2); chk("s2b_noflt", bus.flt, 0);
        repeat (3) nx();
        chk("s2b_eject", bus.state, 3);
        chk("s2b_corks", bus.corks_left, 0);
        chk("s2b_bottles", bus.bottle_count, 2);
        bus.pg = 1'b0;
        nx();

        // 3/4: cork exhaustion, reload, batch rollover
        bus.pg = 1'b1;
        nx();
        bus.ch = 1'b1;
        nx();
        bus.ch = 1'b0;
        chk("s3_nocork", bus.state, 4); chk("s3_al", bus.al, 1); chk("s3_ve", bus.ve, 0);
        bus.ack = 1'b1;
        repeat (2) nx();
        bus.ack = 1'b0;
        chk("s3_ack_ignored", bus.state, 4);
        bus.reload = 1'b1;
        nx();
        bus.reload = 1'b0;
        chk("s3_reload_seal", bus.state, 2); chk("s3_corks_full", bus.corks_left, 2);
        repeat (2) nx();
        chk("s3_last_seal", bus.ve, 1);
        chk("s4_no_pulse_yet", bus.batch_done, 0);
        nx();
        chk("s3_eject", bus.state, 3); chk("s3_corks", bus.corks_left, 1);
        chk("s4_rollover", bus.bottle_count, 0); chk("s4_batch_done", bus.batch_done, 1);
        nx();
        chk("s4_pulse_end", bus.batch_done, 0);
        bus.pg = 1'b0;
        nx();

        // 5: belt block and disable during SEAL
        bus.pg = 1'b1;
        nx();
        bus.ch = 1'b1;
        nx();
        bus.ch = 1'b0;
        nx();
        chk("s5_seal1", bus.state, 2);
        bus.eb = 1'b1;
        #1;
        chk("s5_eb_ve", bus.ve, 0); chk("s5_eb_al", bus.al, 1); chk("s5_eb_m", bus.m, 0);
        repeat (3) nx();
        chk("s5_eb_hold", bus.state, 2);
        bus.eb = 1'b0;
        #1;
        chk("s5_resume_ve", bus.ve, 1); chk("s5_resume_al", bus.al, 0);
        nx();
        chk("s5_ve2", bus.ve, 1);
        nx();
        chk("s5_eject", bus.state, 3); chk("s5_corks", bus.corks_left, 0);
        bus.reload = 1'b1;
        nx();
        bus.reload = 1'b0;
        chk("s5_reload_any", bus.corks_left, 2);
        bus.pg = 1'b0;
        nx();
        bus.pg = 1'b1;
        nx();
        bus.ch = 1'b1;
        nx();
        bus.ch = 1'b0;
        nx();
        bus.enable = 1'b0;
        #1;
        chk("s5_en_ve", bus.ve, 0); chk("s5_en_al", bus.al, 0);
        repeat (3) nx();
        chk("s5_en_hold", bus.state, 2); chk("s5_en_corks", bus.corks_left, 2);
        bus.enable = 1'b1;
        nx();
        chk("s5_en_ve2", bus.ve, 1);
        nx();
        chk("s5_en_eject", bus.state, 3); chk("s5_en_bottles", bus.bottle_count, 2);

        // 6: async reset mid-FILL, reload on last seal cycle
        bus.pg = 1'b0;
        nx();
        bus.pg = 1'b1;
        nx();
        chk("s6_fill", bus.ev, 1);
        #2 rst = 1'b1;
        #1;
        chk("s6_rst_state", bus.state, 0); chk("s6_rst_corks", bus.corks_left, 2);
        chk("s6_rst_bottles", bus.bottle_count, 0); chk("s6_rst_ev", bus.ev, 0);
        #1 rst = 1'b0;
        nx();
        chk("s6_refill", bus.state, 1);
        bus.ch = 1'b1;
        nx();
        bus.ch = 1'b0;
        repeat (2) nx();
        chk("s6_last_seal", bus.state, 2);
        bus.reload = 1'b1;
        nx();
        bus.reload = 1'b0;
        chk("s6_eject", bus.state, 3);
        chk("s6_reload_wins", bus.corks_left, 2);
        chk("s6_bottles", bus.bottle_count, 1);
        bus.pg = 1'b0;
        repeat (3) nx();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/modulo_mef_enchimento_vedacao_param.md
Name: modulo_mef_enchimento_vedacao_param

Overview:
Parametrised filling/sealing controller for one bottle station on the conveyor line. It drives the conveyor motor, the fill valve and the sealer. Beyond the fixed 2-bit controller it adds a fill-timeout fault, a timed seal pulse, an internal cork-stock counter with reload, and batch counting. It sits between the station sensors and the actuators, below the line-level supervisor that consumes al/flt/batch_done.

Parameters:
FILL_TIMEOUT, 8, max cycles ev may stay high without ch before FAULT (>=2)
SEAL_CYCLES, 3, cycles ve is held high per bottle (>=1)
CORK_CAP, 2, corks loaded by a reload (>=1)
BATCH_SIZE, 3, bottles per batch (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
enable  in  1  station enable; low = hold everything, actuators off
pg  in  1  bottle present at station
ch  in  1  bottle full (level sensor)
eb  in  1  emergency/belt block
reload  in  1  cork magazine refilled (1-cycle pulse)
ack  in  1  operator fault acknowledge
m  out  1  conveyor motor
ev  out  1  fill valve
ve  out  1  sealer
al  out  1  alarm
flt  out  1  fill-timeout fault latched
state  out  3  current state code
corks_left  out  $clog2(CORK_CAP+1)  corks remaining
bottle_count  out  $clog2(BATCH_SIZE+1)  bottles done in current batch
batch_done  out  1  1-cycle pulse on batch completion

Behaviour:
- One clock; reset is asynchronous and active-high (rst). Reset: state=MOVE, timers=0, corks_left=CORK_CAP, bottle_count=0, batch_done=0, flt=0.
- Reset state outputs: m=1 if enable & !eb, else 0; ev=ve=al=0.
- States (code): MOVE 0, FILL 1, SEAL 2, EJECT 3, NOCORK 4, FAULT 5. Codes 6/7 go to MOVE on the next edge.
- Outputs are Moore, decoded from state and gated only by enable/eb.
  - MOVE: m=1.
  - FILL: ev=1.
  - SEAL: ve=1.
  - EJECT: m=1.
  - NOCORK: al=1.
  - FAULT: al=1 and flt=1.
- enable=0: state, timers and counters hold; m=ev=ve=0; al/flt keep their state-decoded values.
- eb=1 (with enable=1): same hold behaviour, and al=1.
- Transitions, evaluated only when enable & !eb:
  - MOVE: pg -> FILL. Fill timer cleared on entry.
  - FILL: ch -> SEAL if corks_left>0, else NOCORK. Otherwise timer++. If timer==FILL_TIMEOUT-1 and !ch -> FAULT. ev is therefore high at most FILL_TIMEOUT cycles. ch wins over timeout in the same cycle.
  - SEAL: seal counter runs 0..SEAL_CYCLES-1, so ve is high exactly SEAL_CYCLES cycles. On the last cycle: corks_left--, bottle_count++, -> EJECT.
  - Batch rollover: if bottle_count reaches BATCH_SIZE, it is written 0 instead and batch_done pulses on the following cycle.
  - EJECT: !pg -> MOVE. Stays while the bottle is still present.
  - NOCORK: reload -> SEAL. ack is ignored here.
  - FAULT: ack -> EJECT; flt clears with the state change. reload is allowed but causes no transition.
- reload in any state sets corks_left=CORK_CAP the next cycle. It overrides a same-cycle decrement and needs no enable.
- Counters saturate only via the rules above. corks_left never underflows because SEAL is entered only with corks_left>0.
- No combinational path from pg/ch/reload/ack to outputs.

Test Plan:
All scenarios use defaults FILL_TIMEOUT=8, SEAL_CYCLES=3, CORK_CAP=2, BATCH_SIZE=3.
1. Reset, enable=1, pg=0 -> m=1, state=0. Raise pg -> next edge state=1, ev=1, m=0. Raise ch after 4 cycles -> ve=1 for exactly 3 cycles, then state=3, corks_left=1, bottle_count=1. Drop pg -> state=0.
2. Fill timeout: pg=1, ch held 0 -> ev high 8 cycles, then state=5, al=flt=1. ack -> state=3, flt=0. ch asserted on the 8th cycle -> SEAL instead, no fault.
3. Cork exhaustion: run 2 bottles (corks_left=0); third bottle reaches ch -> state=4, al=1, ve=0. ack has no effect. reload -> corks_left=2, state=2, seal completes with corks_left=1.
4. Batch: 3 bottles complete -> bottle_count sequence 1,2,0 and batch_done high exactly one cycle after the third seal ends.
5. eb=1 mid-SEAL at seal cycle 1 -> ve=0, al=1, counter frozen. eb=0 -> ve resumes for the 2 remaining cycles. Same check with enable=0: al=0, all frozen.
6. rst asserted asynchronously mid-FILL (between edges) -> immediately state=0, corks_left=2, bottle_count=0, ev=0. reload coinciding with the last SEAL cycle -> corks_left=2, not 1.
